// File: rtl/bru_pkg.sv
// -----------------------------------------------------------------------------
// bru_pkg
// Shared definitions for the branch resolve unit:
//   - Funct3 encodings of the conditional branch instructions
//   - BHT 2-bit saturating counter encodings, reset value and update helper
//   - FSM state encoding (IDLE / FLUSH)
// Optional feature macro used by the top level: BRU_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_SNT   = 2'b00;  // strongly not-taken
    localparam bht_ctr_t BHT_WNT   = 2'b01;  // weakly not-taken
    localparam bht_ctr_t BHT_WT    = 2'b10;  // weakly taken
    localparam bht_ctr_t BHT_ST    = 2'b11;  // strongly taken
    localparam bht_ctr_t BHT_RESET = BHT_WNT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } bru_state_e;

    // Saturating 2-bit counter step towards the observed direction.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t res;
        if (taken) begin
            res = (ctr == BHT_ST) ? ctr : bht_ctr_t'(ctr + 2'd1);
        end else begin
            res = (ctr == BHT_SNT) ? ctr : bht_ctr_t'(ctr - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bru_if.sv
// -----------------------------------------------------------------------------
// bru_if
// Bundle between fetch/EX and the branch resolve unit.
//   slave  : the resolve unit (consumes lookup/resolve, drives prediction,
//            redirect and status)
//   master : the surrounding pipeline
// Signals:
//   LookupPC / PredTakenF                 fetch-side prediction lookup
//   ResolveValid, Branch, ForceJump, JumpReg, Funct3, PredTaken,
//   PC, Imm, RsA, RsB                     EX-stage resolve request
//   BranchMux, Redirect, RedirectPC, Flush, IllegalBranch   results
//   BranchCount, MispredCount             performance counters
// -----------------------------------------------------------------------------
interface bru_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] LookupPC;
    logic            PredTakenF;
    logic            ResolveValid;
    logic            Branch;
    logic            ForceJump;
    logic            JumpReg;
    logic [2:0]      Funct3;
    logic            PredTaken;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] Imm;
    logic [XLEN-1:0] RsA;
    logic [XLEN-1:0] RsB;
    logic            BranchMux;
    logic            Redirect;
    logic [XLEN-1:0] RedirectPC;
    logic            Flush;
    logic            IllegalBranch;
    logic [31:0]     BranchCount;
    logic [31:0]     MispredCount;

    modport slave (
        input  LookupPC, ResolveValid, Branch, ForceJump, JumpReg, Funct3,
               PredTaken, PC, Imm, RsA, RsB,
        output PredTakenF, BranchMux, Redirect, RedirectPC, Flush,
               IllegalBranch, BranchCount, MispredCount
    );

    modport master (
        output LookupPC, ResolveValid, Branch, ForceJump, JumpReg, Funct3,
               PredTaken, PC, Imm, RsA, RsB,
        input  PredTakenF, BranchMux, Redirect, RedirectPC, Flush,
               IllegalBranch, BranchCount, MispredCount
    );
endinterface

// File: rtl/bru_bht.sv
// -----------------------------------------------------------------------------
// bru_bht
// Branch history table: BHT_DEPTH entries of 2-bit saturating counters.
// One combinational read port (fetch) and one update port (EX). A read of
// the entry being updated in the same cycle returns the pre-update value.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset (entries -> weakly NT)
//   rd_idx_i/rd_ctr_o read index / counter value
//   upd_en_i          apply one saturating step at upd_idx_i
//   upd_taken_i       direction of the step
// -----------------------------------------------------------------------------
module bru_bht
    import bru_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_ctr_t         rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_ctr_t tbl_q [BHT_DEPTH];

    assign rd_ctr_o = tbl_q[rd_idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                tbl_q[i] <= BHT_RESET;
            end
        end else if (upd_en_i) begin
            tbl_q[upd_idx_i] <= bht_next(tbl_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves beq/bne/blt/bge/bltu/bgeu, jal and jalr in EX, predicts direction
// for fetch from a 2-bit BHT, and raises a registered redirect on mispredict
// (jalr always redirects). After a redirect, resolves are squashed for
// FLUSH_LEN cycles.
// Ports:
//   Clk, Rst_n   clock, async active-low reset
//   bus          bru_if.slave (lookup, resolve request, results, counters)
// Optional feature: define BRU_PERF_CNT_EN to build saturating 32-bit
// BranchCount / MispredCount counters; otherwise both read as 0.
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int FLUSH_LEN = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    bru_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    bru_state_e        state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              branch_mux_q, redirect_q, illegal_q;
    logic [XLEN-1:0]   redirect_pc_q;

    bht_ctr_t          pred_ctr;
    logic              accepted, sel_jalr, sel_jal, sel_br, illegal_f3;
    logic              cond, taken, redirect_d, bht_upd;
    logic [XLEN-1:0]   target;
    logic signed [XLEN-1:0] rs_a_s, rs_b_s;

    bru_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .rd_idx_i    (bus.LookupPC[IDX_W+1:2]),
        .rd_ctr_o    (pred_ctr),
        .upd_en_i    (bht_upd),
        .upd_idx_i   (bus.PC[IDX_W+1:2]),
        .upd_taken_i (taken)
    );

    assign bus.PredTakenF = pred_ctr[1];

    // Instruction class with priority JumpReg > ForceJump > Branch.
    assign sel_jalr   = bus.JumpReg;
    assign sel_jal    = !bus.JumpReg && bus.ForceJump;
    assign sel_br     = !bus.JumpReg && !bus.ForceJump && bus.Branch;
    assign illegal_f3 = (bus.Funct3 == 3'b010) || (bus.Funct3 == 3'b011);

    assign rs_a_s = $signed(bus.RsA);
    assign rs_b_s = $signed(bus.RsB);

    always_comb begin
        cond = 1'b0;
        case (bus.Funct3)
            F3_BEQ:  cond = (bus.RsA == bus.RsB);
            F3_BNE:  cond = (bus.RsA != bus.RsB);
            F3_BLT:  cond = (rs_a_s <  rs_b_s);
            F3_BGE:  cond = (rs_a_s >= rs_b_s);
            F3_BLTU: cond = (bus.RsA <  bus.RsB);
            F3_BGEU: cond = (bus.RsA >= bus.RsB);
            default: cond = 1'b0;
        endcase
    end

    assign taken    = sel_jalr || sel_jal || (sel_br && !illegal_f3 && cond);
    assign accepted = bus.ResolveValid && (state_q == ST_IDLE);

    always_comb begin
        if (sel_jalr) begin
            target = (bus.RsA + bus.Imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else if (taken) begin
            target = bus.PC + bus.Imm;
        end else begin
            target = bus.PC + XLEN'(4);
        end
    end

    // No BTB, so a jalr target is never known at fetch.
    assign redirect_d = accepted && ((taken != bus.PredTaken) || sel_jalr);
    assign bht_upd    = accepted && sel_br && !illegal_f3;

    // Result registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            branch_mux_q  <= 1'b0;
            redirect_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            branch_mux_q <= accepted && taken;
            redirect_q   <= redirect_d;
            illegal_q    <= accepted && sel_br && illegal_f3;
            if (accepted) begin
                redirect_pc_q <= target;
            end
        end
    end

    // FSM: enters FLUSH the cycle after the redirect pulse, so Flush spans
    // the pulse plus FLUSH_LEN cycles.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_q && (FLUSH_LEN > 0)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_LEN - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.BranchMux     = branch_mux_q;
    assign bus.Redirect      = redirect_q;
    assign bus.RedirectPC    = redirect_pc_q;
    assign bus.IllegalBranch = illegal_q;
    assign bus.Flush         = redirect_q || (state_q == ST_FLUSH);

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_cnt_q, mp_cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (accepted && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (redirect_d && (mp_cnt_q != '1)) begin
                mp_cnt_q <= mp_cnt_q + 32'd1;
            end
        end
    end

    assign bus.BranchCount  = br_cnt_q;
    assign bus.MispredCount = mp_cnt_q;
`else
    assign bus.BranchCount  = 32'd0;
    assign bus.MispredCount = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit (XLEN=32, BHT_DEPTH=64, FLUSH_LEN=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic Clk;
    logic Rst_n;
    int   n_chk;
    int   n_pass;

    bru_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .FLUSH_LEN (2)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ResolveValid = 1'b0;
        bus.Branch       = 1'b0;
        bus.ForceJump    = 1'b0;
        bus.JumpReg      = 1'b0;
        bus.Funct3       = 3'b000;
        bus.PredTaken    = 1'b0;
    endtask

    // Present one resolve for a single cycle; returns just after the edge.
    task automatic resolve(input logic br, input logic fj, input logic jr,
                           input logic [2:0] f3, input logic pt,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b);
        bus.ResolveValid = 1'b1;
        bus.Branch       = br;
        bus.ForceJump    = fj;
        bus.JumpReg      = jr;
        bus.Funct3       = f3;
        bus.PredTaken    = pt;
        bus.PC           = pc;
        bus.Imm          = imm;
        bus.RsA          = a;
        bus.RsB          = b;
        tick();
        idle_inputs();
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        bus.LookupPC = pc;
        #1;
        chk(tag, {31'd0, bus.PredTakenF}, {31'd0, exp});
    endtask

    initial begin
        logic [31:0] exp_br_cnt;
        logic [31:0] exp_mp_cnt;
        n_chk  = 0;
        n_pass = 0;
        Rst_n  = 1'b0;
        idle_inputs();
        bus.LookupPC = '0;
        bus.PC       = '0;
        bus.Imm      = '0;
        bus.RsA      = '0;
        bus.RsB      = '0;

        // ---- 1. reset state ----
        tick();
        chk("rst_branchmux", {31'd0, bus.BranchMux}, 32'd0);
        chk("rst_redirect",  {31'd0, bus.Redirect}, 32'd0);
        chk("rst_redirpc",   bus.RedirectPC, 32'd0);
        chk("rst_flush",     {31'd0, bus.Flush}, 32'd0);
        chk("rst_illegal",   {31'd0, bus.IllegalBranch}, 32'd0);
        chk("rst_brcnt",     bus.BranchCount, 32'd0);
        chk("rst_mpcnt",     bus.MispredCount, 32'd0);
        for (int i = 0; i < 64; i++) begin
            pred_at("rst_pred", 32'(i) << 2, 1'b0);
        end
        Rst_n = 1'b1;
        tick();

        // ---- 2. beq taken, predicted not-taken ----
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5);
        chk("beq_branchmux", {31'd0, bus.BranchMux}, 32'd1);
        chk("beq_redirect",  {31'd0, bus.Redirect}, 32'd1);
        chk("beq_redirpc",   bus.RedirectPC, 32'h120);
        chk("beq_flush0",    {31'd0, bus.Flush}, 32'd1);
        tick();
        chk("beq_redirect_pulse", {31'd0, bus.Redirect}, 32'd0);
        chk("beq_flush1",    {31'd0, bus.Flush}, 32'd1);
        tick();
        chk("beq_flush2",    {31'd0, bus.Flush}, 32'd1);
        tick();
        chk("beq_flush_end", {31'd0, bus.Flush}, 32'd0);
        pred_at("beq_bht_wt", 32'h100, 1'b1);

        // ---- 3. blt signed taken, bltu unsigned not taken ----
        resolve(1'b1, 1'b0, 1'b0, 3'b100, 1'b1, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        chk("blt_branchmux", {31'd0, bus.BranchMux}, 32'd1);
        chk("blt_redirect",  {31'd0, bus.Redirect}, 32'd0);
        chk("blt_redirpc",   bus.RedirectPC, 32'h240);
        chk("blt_flush",     {31'd0, bus.Flush}, 32'd0);
        resolve(1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        chk("bltu_branchmux", {31'd0, bus.BranchMux}, 32'd0);
        chk("bltu_redirect",  {31'd0, bus.Redirect}, 32'd1);
        chk("bltu_redirpc",   bus.RedirectPC, 32'h204);
        tick(); tick(); tick();

        // ---- 4. jalr always redirects, bit 0 cleared ----
        resolve(1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 32'h300, 32'h0, 32'h1003, 32'd0);
        chk("jalr_branchmux", {31'd0, bus.BranchMux}, 32'd1);
        chk("jalr_redirect",  {31'd0, bus.Redirect}, 32'd1);
        chk("jalr_redirpc",   bus.RedirectPC, 32'h1002);
        tick(); tick(); tick();

        // jal wins over a not-taken Branch and leaves the BHT alone
        resolve(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 32'h400, 32'h10, 32'd1, 32'd2);
        chk("jal_branchmux", {31'd0, bus.BranchMux}, 32'd1);
        chk("jal_redirect",  {31'd0, bus.Redirect}, 32'd0);
        chk("jal_redirpc",   bus.RedirectPC, 32'h410);
        pred_at("jal_no_bht_upd", 32'h400, 1'b1);

        // ---- 5. BHT counter walk at index 5 (PC 0x14) ----
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h14, 32'h8, 32'd7, 32'd7);
        chk("bht_t1_redirect", {31'd0, bus.Redirect}, 32'd1);
        pred_at("bht_01_to_10", 32'h14, 1'b1);
        tick(); tick(); tick();
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h14, 32'h8, 32'd7, 32'd7);
        chk("bht_t2_redirect", {31'd0, bus.Redirect}, 32'd0);
        pred_at("bht_10_to_11", 32'h14, 1'b1);
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h14, 32'h8, 32'd7, 32'd7);
        chk("bht_t3_redirect", {31'd0, bus.Redirect}, 32'd0);
        pred_at("bht_11_sat", 32'h14, 1'b1);
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h14, 32'h8, 32'd1, 32'd2);
        chk("bht_nt1_redirect", {31'd0, bus.Redirect}, 32'd1);
        chk("bht_nt1_redirpc",  bus.RedirectPC, 32'h18);
        pred_at("bht_11_to_10", 32'h14, 1'b1);
        tick();
        chk("bht_in_flush", {31'd0, bus.Flush}, 32'd1);
        // resolve while in FLUSH: ignored entirely
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h14, 32'h8, 32'd1, 32'd2);
        chk("flush_ign_redirect",  {31'd0, bus.Redirect}, 32'd0);
        chk("flush_ign_branchmux", {31'd0, bus.BranchMux}, 32'd0);
        tick();
        chk("flush_ign_done", {31'd0, bus.Flush}, 32'd0);
        pred_at("flush_ign_no_upd", 32'h14, 1'b1);
        resolve(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h14, 32'h8, 32'd1, 32'd2);
        chk("bht_nt2_redirect", {31'd0, bus.Redirect}, 32'd1);
        pred_at("bht_10_to_01", 32'h14, 1'b0);
        tick(); tick(); tick();

        // ---- 6. illegal Funct3 ----
        resolve(1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 32'h500, 32'h20, 32'd3, 32'd3);
        chk("illegal_pulse",     {31'd0, bus.IllegalBranch}, 32'd1);
        chk("illegal_redirect",  {31'd0, bus.Redirect}, 32'd0);
        chk("illegal_branchmux", {31'd0, bus.BranchMux}, 32'd0);
        pred_at("illegal_no_bht_upd", 32'h500, 1'b1);
        tick();
        chk("illegal_pulse_end", {31'd0, bus.IllegalBranch}, 32'd0);

`ifdef BRU_PERF_CNT_EN
        exp_br_cnt = 32'd11;
        exp_mp_cnt = 32'd6;
`else
        exp_br_cnt = 32'd0;
        exp_mp_cnt = 32'd0;
`endif
        chk("branch_count", bus.BranchCount, exp_br_cnt);
        chk("mispred_count", bus.MispredCount, exp_mp_cnt);

        // ---- reset in the middle of FLUSH ----
        resolve(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h600, 32'h0, 32'h2000, 32'd0);
        tick();
        chk("midflush_pre", {31'd0, bus.Flush}, 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("midflush_flush",    {31'd0, bus.Flush}, 32'd0);
        chk("midflush_redirect", {31'd0, bus.Redirect}, 32'd0);
        chk("midflush_redirpc",  bus.RedirectPC, 32'd0);
        chk("midflush_brcnt",    bus.BranchCount, 32'd0);
        pred_at("midflush_bht0", 32'h100, 1'b0);
        pred_at("midflush_bht5", 32'h14, 1'b0);
        tick();
        Rst_n = 1'b1;
        tick();
        chk("post_rst_flush", {31'd0, bus.Flush}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
